// File: rtl/draw_pkg.sv
// Purpose: shared constants and types for the draw write path. This covers the
// framebuffer geometry, the pixel colour width, the source-select width, the
// arbiter state encoding and the IDs of the sources on the write bus.
// Ports: none (package).
package draw_pkg;

  localparam int COLOR_DEPTH       = 9;
  localparam int DRAW_WIDTH        = 160;
  localparam int DRAW_HEIGHT       = 120;
  localparam int DRAW_WIDTH_ADDRW  = 8;
  localparam int DRAW_HEIGHT_ADDRW = 7;
  localparam int FB_ADDRW          = 15;
  localparam int FB_SIZE           = DRAW_WIDTH * DRAW_HEIGHT;

  localparam int NUM_SOURCES      = 4;
  localparam int SOURCE_SEL_ADDRW = 2;
  localparam int TIMEOUT_CYCLES   = 1024;

  // Sources are granted in ascending ID order.
  // A later ID paints over an earlier one.
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_STARFIELD = 2'd0;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_SPRITE_A  = 2'd1;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_SPRITE_B  = 2'd2;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_HUD       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SELECT,
    ST_WAIT_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/draw_write_arbiter_fb_addr_calc.sv
// Purpose: registered pixel stage. It range-checks an accepted pixel and drops
// the pixel if it is transparent or off-screen. Otherwise it emits one
// framebuffer write one cycle later at address y*DRAW_WIDTH + x.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pix_valid        a pixel is accepted this cycle
//   pix_transparent  discard this pixel
//   pix_x, pix_y     pixel coordinates
//   pix_color        pixel colour
//   we_q             registered write strobe
//   addr_q           registered linear address (holds the last written address)
//   data_q           registered write colour (holds the last written colour)
module draw_write_arbiter_fb_addr_calc
  import draw_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  input  logic                         pix_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  pix_x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] pix_y,
  input  logic [COLOR_DEPTH-1:0]       pix_color,
  output logic                         we_q,
  output logic [FB_ADDRW-1:0]          addr_q,
  output logic [COLOR_DEPTH-1:0]       data_q
);

  logic [FB_ADDRW-1:0]    y_ext;
  logic [FB_ADDRW-1:0]    row_base;
  logic                   in_range;
  logic                   we_d;
  logic [FB_ADDRW-1:0]    addr_d;
  logic [COLOR_DEPTH-1:0] data_d;

  assign y_ext = FB_ADDRW'(pix_y);

  // When the width is 160, the product 160*y is formed as (y<<7) + (y<<5).
  // This avoids a hardware multiplier.
  generate
    if (DRAW_WIDTH == 160) begin : g_shift_add
      assign row_base = (y_ext << 7) + (y_ext << 5);
    end else begin : g_mult
      assign row_base = y_ext * FB_ADDRW'(DRAW_WIDTH);
    end
  endgenerate

  always_comb begin
    in_range = (pix_x < DRAW_WIDTH_ADDRW'(DRAW_WIDTH)) &&
               (pix_y < DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT));
    we_d     = pix_valid && !pix_transparent && in_range;
    addr_d   = addr_q;
    data_d   = data_q;
    if (we_d) begin
      addr_d = row_base + FB_ADDRW'(pix_x);
      data_d = pix_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/draw_write_arbiter.sv
// Purpose: consumer of the shared draw write bus. For each frame the arbiter
// can first clear the back buffer. It then grants the bus to each source in ID
// order and forwards every opaque, on-screen pixel as a framebuffer write.
// draw_done pulses for one cycle when the frame is composed.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_start           pulse that starts composing a frame (ignored while busy)
//   clear_en, clear_color run a clear pass first, using this colour
//   write_source_sel      granted source ID
//   write_awaited         arbiter is ready for the granted source's pixels
//   write_active, write_* pixel stream from the granted source
//   fb_we/fb_addr/fb_data framebuffer write port
//   busy, draw_done       status outputs
//   overrun               sticky flag: frame_start arrived while busy
//   source_timeout        sticky flags: sources skipped because they never started
module draw_write_arbiter
  import draw_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         clear_en,
  input  logic [COLOR_DEPTH-1:0]       clear_color,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic                         write_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [FB_ADDRW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         busy,
  output logic                         draw_done,
  output logic                         overrun,
  output logic [NUM_SOURCES-1:0]       source_timeout
);

  localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [FB_ADDRW-1:0]         CLEAR_LAST = FB_ADDRW'(FB_SIZE - 1);
  localparam logic [TO_CNT_W-1:0]         TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_LAST   = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);

  arb_state_e                  state_q, state_d;
  logic [SOURCE_SEL_ADDRW-1:0] src_q, src_d;
  logic [FB_ADDRW-1:0]         clear_cnt_q, clear_cnt_d;
  logic [TO_CNT_W-1:0]         timeout_cnt_q, timeout_cnt_d;
  logic                        overrun_q, overrun_d;
  logic [NUM_SOURCES-1:0]      source_timeout_q, source_timeout_d;
  logic                        advance;
  logic                        accept;
  logic                        pix_we;
  logic [FB_ADDRW-1:0]         pix_addr;
  logic [COLOR_DEPTH-1:0]      pix_data;

  // Pixels are only sampled while the bus is granted and awaited.
  // Outside those states the write_* inputs may float.
  assign accept = ((state_q == ST_WAIT_ACTIVE) || (state_q == ST_DRAIN)) && write_active;

  draw_write_arbiter_fb_addr_calc u_fb_addr_calc (
    .clk             (clk),
    .rst             (rst),
    .pix_valid       (accept),
    .pix_transparent (write_transparent),
    .pix_x           (write_x_addr),
    .pix_y           (write_y_addr),
    .pix_color       (write_color_data),
    .we_q            (pix_we),
    .addr_q          (pix_addr),
    .data_q          (pix_data)
  );

  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    clear_cnt_d      = clear_cnt_q;
    timeout_cnt_d    = timeout_cnt_q;
    overrun_d        = overrun_q;
    source_timeout_d = source_timeout_q;
    advance          = 1'b0;

    if (frame_start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          overrun_d        = 1'b0;
          source_timeout_d = '0;
          src_d            = SRC_STARFIELD;
          clear_cnt_d      = '0;
          state_d          = clear_en ? ST_CLEAR : ST_SELECT;
        end
      end
      ST_CLEAR: begin
        if (clear_cnt_q == CLEAR_LAST) begin
          clear_cnt_d = '0;
          state_d     = ST_SELECT;
        end else begin
          clear_cnt_d = clear_cnt_q + FB_ADDRW'(1);
        end
      end
      ST_SELECT: begin
        timeout_cnt_d = '0;
        state_d       = ST_WAIT_ACTIVE;
      end
      ST_WAIT_ACTIVE: begin
        // The counter reaches TO_LAST in the TIMEOUT_CYCLES-th idle cycle.
        // The source is skipped at that point.
        if (write_active) begin
          state_d = ST_DRAIN;
        end else if (timeout_cnt_q == TO_LAST) begin
          source_timeout_d[src_q] = 1'b1;
          advance                 = 1'b1;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!write_active) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (src_q == SRC_LAST) begin
        state_d = ST_DONE;
      end else begin
        src_d   = src_q + SOURCE_SEL_ADDRW'(1);
        state_d = ST_SELECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      src_q            <= '0;
      clear_cnt_q      <= '0;
      timeout_cnt_q    <= '0;
      overrun_q        <= 1'b0;
      source_timeout_q <= '0;
    end else begin
      state_q          <= state_d;
      src_q            <= src_d;
      clear_cnt_q      <= clear_cnt_d;
      timeout_cnt_q    <= timeout_cnt_d;
      overrun_q        <= overrun_d;
      source_timeout_q <= source_timeout_d;
    end
  end

  // The clear pass and pixel writes never overlap.
  // The last pixel of a source lands in SELECT or DONE, never in CLEAR.
  assign fb_we   = (state_q == ST_CLEAR) || pix_we;
  assign fb_addr = (state_q == ST_CLEAR) ? clear_cnt_q : pix_addr;
  assign fb_data = (state_q == ST_CLEAR) ? clear_color : pix_data;

  assign write_source_sel = src_q;
  assign write_awaited    = (state_q == ST_WAIT_ACTIVE) || (state_q == ST_DRAIN);
  assign busy             = (state_q != ST_IDLE);
  assign draw_done        = (state_q == ST_DONE);
  assign overrun          = overrun_q;
  assign source_timeout   = source_timeout_q;

endmodule

// File: tb/tb_draw_write_arbiter.sv
// Directed bench for draw_write_arbiter.
// Expected values are worked out by hand from the framebuffer geometry (160x120)
// and the arbiter's cycle timing.
module tb_draw_write_arbiter;
  import draw_pkg::*;

  logic                         clk;
  logic                         rst;
  logic                         frame_start;
  logic                         clear_en;
  logic [COLOR_DEPTH-1:0]       clear_color;
  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
  logic                         write_awaited;
  logic                         write_active;
  logic [COLOR_DEPTH-1:0]       write_color_data;
  logic                         write_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;
  logic                         fb_we;
  logic [FB_ADDRW-1:0]          fb_addr;
  logic [COLOR_DEPTH-1:0]       fb_data;
  logic                         busy;
  logic                         draw_done;
  logic                         overrun;
  logic [NUM_SOURCES-1:0]       source_timeout;

  int totalChecks;
  int badChecks;
  int weCount;
  int seqErrs;
  int n;

  draw_write_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .clear_en          (clear_en),
    .clear_color       (clear_color),
    .write_source_sel  (write_source_sel),
    .write_awaited     (write_awaited),
    .write_active      (write_active),
    .write_color_data  (write_color_data),
    .write_transparent (write_transparent),
    .write_x_addr      (write_x_addr),
    .write_y_addr      (write_y_addr),
    .fb_we             (fb_we),
    .fb_addr           (fb_addr),
    .fb_data           (fb_data),
    .busy              (busy),
    .draw_done         (draw_done),
    .overrun           (overrun),
    .source_timeout    (source_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic act, input logic transp, input int x, input int y,
                               input logic [COLOR_DEPTH-1:0] color);
    write_active      = act;
    write_transparent = transp;
    write_x_addr      = DRAW_WIDTH_ADDRW'(x);
    write_y_addr      = DRAW_HEIGHT_ADDRW'(y);
    write_color_data  = color;
    step();
    if (fb_we) weCount++;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    weCount     = 0;
    rst = 1'b1; frame_start = 1'b0; clear_en = 1'b0; clear_color = '0;
    write_active = 1'b0; write_color_data = '0; write_transparent = 1'b0;
    write_x_addr = '0; write_y_addr = '0;
    repeat (3) step();

    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_fb_we", 32'(fb_we), 0);
    checkOutput("rst_awaited", 32'(write_awaited), 0);
    checkOutput("rst_done", 32'(draw_done), 0);
    checkOutput("rst_fb_addr", 32'(fb_addr), 0);
    checkOutput("rst_fb_data", 32'(fb_data), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_timeout", 32'(source_timeout), 0);
    checkOutput("rst_sel", 32'(write_source_sel), 0);
    rst = 1'b0;
    step();

    // Frame 1: clear pass, then all sources stay idle and time out.
    clear_en = 1'b1; clear_color = 9'h049; frame_start = 1'b1;
    step();
    frame_start = 1'b0; clear_en = 1'b0;
    checkOutput("clear_first_addr", 32'(fb_addr), 0);
    seqErrs = 0;
    for (int i = 0; i < FB_SIZE; i++) begin
      if (!fb_we || fb_addr != FB_ADDRW'(i) || fb_data != 9'h049) seqErrs++;
      step();
    end
    checkOutput("clear_seq_errs", 32'(seqErrs), 0);
    checkOutput("post_clear_we", 32'(fb_we), 0);
    checkOutput("post_clear_sel", 32'(write_source_sel), 0);
    checkOutput("post_clear_awaited", 32'(write_awaited), 0);
    n = 0;
    while (!draw_done && n < 6000) begin step(); n++; end
    checkOutput("idle_frame_done_cycles", 32'(n), 4100);
    checkOutput("idle_frame_timeouts", 32'(source_timeout), 32'h0F);
    step();
    checkOutput("idle_after_done", 32'(busy), 0);

    // Frame 2: no clear; src0 sends three pixels, the last one off-screen.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checkOutput("f2_select_sel", 32'(write_source_sel), 0);
    checkOutput("f2_select_awaited", 32'(write_awaited), 0);
    step();
    checkOutput("f2_wait_awaited", 32'(write_awaited), 1);
    applyStimulus(1'b1, 1'b0, 5, 7, 9'h111);
    checkOutput("px_5_7_we", 32'(fb_we), 1);
    checkOutput("px_5_7_addr", 32'(fb_addr), 1125);
    checkOutput("px_5_7_data", 32'(fb_data), 32'h111);
    applyStimulus(1'b1, 1'b0, 159, 119, 9'h0AA);
    checkOutput("px_last_we", 32'(fb_we), 1);
    checkOutput("px_last_addr", 32'(fb_addr), 19199);
    applyStimulus(1'b1, 1'b0, 160, 0, 9'h1FF);
    checkOutput("px_oob_x_we", 32'(fb_we), 0);
    checkOutput("px_oob_x_addr_hold", 32'(fb_addr), 19199);
    applyStimulus(1'b0, 1'b0, 0, 0, 9'h000);
    checkOutput("src1_select_sel", 32'(write_source_sel), 1);
    checkOutput("src1_select_awaited", 32'(write_awaited), 0);

    // src1 sends four pixels; two of them are transparent.
    step();
    weCount = 0;
    applyStimulus(1'b1, 1'b0, 0, 0, 9'h007);
    applyStimulus(1'b1, 1'b1, 1, 0, 9'h007);
    applyStimulus(1'b1, 1'b0, 2, 0, 9'h038);
    checkOutput("src1_px2_addr", 32'(fb_addr), 2);
    applyStimulus(1'b1, 1'b1, 3, 0, 9'h038);
    applyStimulus(1'b0, 1'b0, 0, 0, 9'h000);
    checkOutput("src1_we_count", 32'(weCount), 2);
    checkOutput("src2_select_sel", 32'(write_source_sel), 2);
    checkOutput("src2_select_awaited", 32'(write_awaited), 0);

    // src2 never starts and is skipped after the timeout.
    step();
    n = 0;
    while (write_awaited && n < 2000) begin step(); n++; end
    checkOutput("src2_wait_cycles", 32'(n), 1024);
    checkOutput("src2_timeout_flags", 32'(source_timeout), 32'h4);
    checkOutput("src3_select_sel", 32'(write_source_sel), 3);

    // src3 streams while frame_start is pulsed mid-drain.
    step();
    applyStimulus(1'b1, 1'b0, 10, 1, 9'h0C3);
    checkOutput("src3_px0_addr", 32'(fb_addr), 170);
    frame_start = 1'b1;
    applyStimulus(1'b1, 1'b0, 11, 1, 9'h0C3);
    frame_start = 1'b0;
    checkOutput("ovr_flag", 32'(overrun), 1);
    checkOutput("ovr_px1_addr", 32'(fb_addr), 171);
    checkOutput("ovr_busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 9'h000);
    checkOutput("f2_done", 32'(draw_done), 1);
    checkOutput("f2_done_awaited", 32'(write_awaited), 0);
    checkOutput("f2_done_sel_hold", 32'(write_source_sel), 3);
    step();
    checkOutput("f2_idle_busy", 32'(busy), 0);
    checkOutput("f2_idle_done", 32'(draw_done), 0);
    checkOutput("f2_idle_sel_hold", 32'(write_source_sel), 3);
    checkOutput("f2_idle_overrun_sticky", 32'(overrun), 1);
    checkOutput("f2_idle_timeout_sticky", 32'(source_timeout), 32'h4);

    // Frame 3: an accepted frame_start clears the flags; reset mid-drain aborts.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checkOutput("f3_overrun_cleared", 32'(overrun), 0);
    checkOutput("f3_timeout_cleared", 32'(source_timeout), 0);
    checkOutput("f3_sel", 32'(write_source_sel), 0);
    step();
    applyStimulus(1'b1, 1'b0, 20, 2, 9'h155);
    checkOutput("f3_px_addr", 32'(fb_addr), 340);
    frame_start = 1'b1;
    applyStimulus(1'b1, 1'b0, 21, 2, 9'h155);
    frame_start = 1'b0;
    checkOutput("f3_overrun_set", 32'(overrun), 1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 22, 2, 9'h155);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_fb_we", 32'(fb_we), 0);
    checkOutput("midrst_awaited", 32'(write_awaited), 0);
    checkOutput("midrst_overrun", 32'(overrun), 0);
    checkOutput("midrst_fb_addr", 32'(fb_addr), 0);
    checkOutput("midrst_sel", 32'(write_source_sel), 0);
    frame_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 9'h000);
    frame_start = 1'b0;
    rst = 1'b0;
    checkOutput("rst_wins_frame_start", 32'(busy), 0);

    // Frame 4 starts fresh after the reset: src0 draws one pixel, the rest time out.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checkOutput("f4_busy", 32'(busy), 1);
    step();
    applyStimulus(1'b1, 1'b0, 0, 119, 9'h0F0);
    checkOutput("f4_px_we", 32'(fb_we), 1);
    checkOutput("f4_px_addr", 32'(fb_addr), 19040);
    checkOutput("f4_px_data", 32'(fb_data), 32'h0F0);
    applyStimulus(1'b0, 1'b0, 0, 0, 9'h000);
    n = 0;
    while (!draw_done && n < 5000) begin step(); n++; end
    checkOutput("f4_done_cycles", 32'(n), 3075);
    checkOutput("f4_timeout_flags", 32'(source_timeout), 32'hE);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
